// File: rtl/n_bit_muxnx1_arb.sv
`default_nettype none
// ============================================================================
// Module      : n_bit_muxnx1_arb
// Description : CH-channel, N-bit registered multiplexer with valid/ready
//               handshakes and a built-in arbiter. One valid channel wins per
//               cycle and its word is presented from a single-entry output
//               register together with the winning channel index.
//               Optional feature macro: N_MUX_RR_EN
//                 defined   -> round-robin arbitration (rotating pointer)
//                 undefined -> fixed priority, channel 0 highest
// Revision    : 1.0 - initial release
// ============================================================================
module n_bit_muxnx1_arb #(
    parameter int N  = 8,
    parameter int CH = 4
) (
    input  logic                       clk,
    input  logic                       rst,        // synchronous, active-low
    input  logic [CH*N-1:0]            in_data,
    input  logic [CH-1:0]              in_valid,
    output logic [CH-1:0]              in_ready,
    output logic [N-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(CH)-1:0]      out_grant
);

    localparam int SELW = $clog2(CH);
    localparam int SW1  = SELW + 1;

    // Output register
    logic [N-1:0]     r_data;
    logic [SELW-1:0]  r_grant;
    logic             r_valid;

    // Arbitration and handshake wires
    logic [SELW-1:0]  w_win;
    logic             w_any;
    logic             w_can_load;
    logic             w_load;
    logic [N-1:0]     w_data;
    logic [CH-1:0]    w_in_ready;

    assign w_any      = |in_valid;
    // Register is free when empty or when its word leaves this cycle, which
    // lets a drain and a load share one cycle with no bubble.
    assign w_can_load = ~r_valid | out_ready;
    // rst gates the handshake so no transfer can complete on a reset edge.
    assign w_load     = w_can_load & w_any & rst;

`ifdef N_MUX_RR_EN
    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  w_ptr_next;

    // Round-robin winner: first valid channel searching ptr, ptr+1, ... with wrap
    always_comb begin
        logic             found;
        logic [SELW:0]    idx;
        w_win = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CH; i++) begin
            idx = {1'b0, r_ptr} + SW1'(i);
            if (idx >= SW1'(CH)) begin
                idx = idx - SW1'(CH);
            end
            if (!found && in_valid[idx[SELW-1:0]]) begin
                found = 1'b1;
                w_win = idx[SELW-1:0];
            end
        end
    end

    // Pointer advances past the winner; explicit wrap keeps it below CH
    always_comb begin
        w_ptr_next = '0;
        if (w_win != SELW'(CH - 1)) begin
            w_ptr_next = w_win + SELW'(1);
        end
    end

    // Priority pointer register, moves only on an accepted input word
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_load) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    // Fixed-priority winner: scan from the top so the lowest valid index wins
    always_comb begin
        w_win = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_win = SELW'(i);
            end
        end
    end
`endif

    // Select the winning channel's word; only feeds the output register
    always_comb begin
        w_data = '0;
        for (int c = 0; c < CH; c++) begin
            if (w_win == SELW'(c)) begin
                w_data = in_data[c*N +: N];
            end
        end
    end

    // One-hot accept for the winner only; zero while stalled, idle or in reset
    always_comb begin
        w_in_ready = '0;
        for (int c = 0; c < CH; c++) begin
            w_in_ready[c] = w_load && (w_win == SELW'(c));
        end
    end

    // Output register: load on input transfer, else clear valid on drain
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_data;
            r_grant <= w_win;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_data;
    assign out_grant = r_grant;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_n_bit_muxnx1_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_n_bit_muxnx1_arb
// Description : Scoreboard bench for n_bit_muxnx1_arb (N=8, CH=4). Stimulus
//               pushes the expected {grant, data} of every accepted word; a
//               monitor pops and compares whenever a word leaves the output.
//               Follows N_MUX_RR_EN to pick round-robin or fixed-priority
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n_bit_muxnx1_arb;

    localparam int N  = 8;
    localparam int CH = 4;

    logic            clk;
    logic            rst;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_grant;

    int total;
    int bad;

    logic [9:0] sb_q[$];   // {grant[1:0], data[7:0]}

    n_bit_muxnx1_arb #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_grant (out_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor: a word leaves when out_valid & out_ready at the coming edge
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [9:0] e;
                e = sb_q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                chk("out_grant", {30'd0, out_grant}, {30'd0, e[9:8]});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_rdy;
        logic [7:0] fdat [4];
        total = 0;
        bad   = 0;
        fdat[0] = 8'hA0; fdat[1] = 8'hB1; fdat[2] = 8'hC2; fdat[3] = 8'hD3;

        // ---- Reset with all inputs active ----
        rst       = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'hD3C2B1A0;
        out_ready = 1'b1;
        settle();
        chk("rst_in_ready", {28'd0, in_ready}, 32'h0);
        cyc();
        cyc();
        chk("rst_in_ready2", {28'd0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_out_data", {24'd0, out_data}, 32'h0);
        chk("rst_out_grant", {30'd0, out_grant}, 32'h0);

        // First transfer on the cycle after rst rises: channel 0 wins
        rst = 1'b1;
        settle();
        chk("first_in_ready", {28'd0, in_ready}, 32'h1);
        sb_q.push_back({2'd0, 8'hA0});
        cyc();
        chk("first_out_valid", {31'd0, out_valid}, 32'h1);

        // ---- Single channel 2 ----
        in_valid = 4'b0100;
        in_data  = 32'h11A52233;
        settle();
        chk("single_in_ready", {28'd0, in_ready}, 32'h4);
        sb_q.push_back({2'd2, 8'hA5});
        cyc();
        in_valid = 4'b0000;
        settle();
        chk("idle_in_ready", {28'd0, in_ready}, 32'h0);
        cyc();
        chk("drain_out_valid", {31'd0, out_valid}, 32'h0);
        chk("drain_keep_data", {24'd0, out_data}, 32'hA5);
        chk("drain_keep_grant", {30'd0, out_grant}, 32'h2);

        // ---- Back-pressure ----
        in_valid = 4'b0001;
        in_data  = 32'h0000003C;
        settle();
        chk("bp_load_in_ready", {28'd0, in_ready}, 32'h1);
        sb_q.push_back({2'd0, 8'h3C});
        cyc();
        for (int k = 0; k < 3; k++) begin
            logic [3:0] pat [3];
            pat[0] = 4'b1010; pat[1] = 4'b1111; pat[2] = 4'b0110;
            out_ready = 1'b0;
            in_valid  = pat[k];
            in_data   = 32'h01020304 * (k + 5);
            settle();
            chk("stall_in_ready", {28'd0, in_ready}, 32'h0);
            chk("stall_out_data", {24'd0, out_data}, 32'h3C);
            chk("stall_out_valid", {31'd0, out_valid}, 32'h1);
            cyc();
        end
        in_valid  = 4'b0010;
        in_data   = 32'h00005A00;
        out_ready = 1'b1;
        settle();
        chk("bp_release_in_ready", {28'd0, in_ready}, 32'h2);
        chk("bp_release_data", {24'd0, out_data}, 32'h3C);
        sb_q.push_back({2'd1, 8'h5A});
        cyc();
        chk("nobubble_valid", {31'd0, out_valid}, 32'h1);
        chk("nobubble_data", {24'd0, out_data}, 32'h5A);
        in_valid = 4'b0000;
        cyc();

        // ---- Reset mid-stall ----
        in_valid = 4'b1000;
        in_data  = 32'h77000000;
        settle();
        chk("ms_load_in_ready", {28'd0, in_ready}, 32'h8);
        sb_q.push_back({2'd3, 8'h77});
        cyc();
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        settle();
        chk("ms_held_valid", {31'd0, out_valid}, 32'h1);
        chk("ms_held_data", {24'd0, out_data}, 32'h77);
        cyc();
        rst      = 1'b0;
        in_valid = 4'b1111;
        in_data  = 32'hD3C2B1A0;
        settle();
        chk("ms_rst_in_ready", {28'd0, in_ready}, 32'h0);
        sb_q.delete();   // held word is discarded by reset
        cyc();
        chk("ms_rst_valid", {31'd0, out_valid}, 32'h0);
        chk("ms_rst_data", {24'd0, out_data}, 32'h0);
        chk("ms_rst_grant", {30'd0, out_grant}, 32'h0);
        rst       = 1'b1;
        out_ready = 1'b1;
        settle();
        chk("ms_first_in_ready", {28'd0, in_ready}, 32'h1);
        sb_q.push_back({2'd0, fdat[0]});
        cyc();

`ifdef N_MUX_RR_EN
        // ---- Round-robin fairness: 0 already granted, expect 1,2,3,0,1,2,3 ----
        for (int i = 1; i < 8; i++) begin
            int g;
            g = i % 4;
            e_rdy = 4'b0001 << g;
            settle();
            chk("rr_in_ready", {28'd0, in_ready}, {28'd0, e_rdy});
            sb_q.push_back({2'(g), fdat[g]});
            cyc();
        end
        // After a grant of 3: 1001 -> grant 0 then 3
        in_valid = 4'b1001;
        settle();
        chk("rr_1001_first", {28'd0, in_ready}, 32'h1);
        sb_q.push_back({2'd0, fdat[0]});
        cyc();
        chk("rr_1001_second", {28'd0, in_ready}, 32'h8);
        sb_q.push_back({2'd3, fdat[3]});
        cyc();
`else
        // ---- Fixed priority: 1110 always grants channel 1 ----
        in_valid = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("fp_in_ready", {28'd0, in_ready}, 32'h2);
            sb_q.push_back({2'd1, fdat[1]});
            cyc();
        end
`endif
        in_valid = 4'b0000;
        cyc();
        cyc();
        cyc();
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("final_out_valid", {31'd0, out_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
